// File: rtl/imem_axil_slave.sv
// AXI-lite read-only responder for instruction memory: one outstanding read,
// fetched from a synchronous 64-bit RAM after LAT wait cycles.
module imem_axil_slave #(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 64,
  parameter int                DEPTH  = 65536,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int                LAT    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ARVALID,
  input  logic [ADDR_W-1:0]          ARADDR,
  output logic                       ARREADY,
  output logic                       RVALID,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  input  logic                       RREADY,
  output logic                       mem_en,
  output logic [$clog2(DEPTH)-1:0]   mem_addr,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int MEM_AW = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One extra bit so BASE + DEPTH*8 cannot wrap at the top of the address map.
  localparam logic [ADDR_W:0] BASE_X = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0] END_X  = BASE_X + ((ADDR_W+1)'(DEPTH) << 3);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ISSUE,
    CAPT,
    RESP
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        ar_resp;
  logic              ar_hs;

  function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return MEM_AW'((a - BASE) >> 3);
  endfunction

  assign ARREADY = !rst && (state == IDLE || (state == RESP && RREADY));
  assign ar_hs   = ARVALID && ARREADY;

  // Out-of-range wins over misalignment.
  always_comb begin
    ar_resp = RESP_OKAY;
    if ({1'b0, ARADDR} < BASE_X || {1'b0, ARADDR} >= END_X)
      ar_resp = RESP_DECERR;
    else if (ARADDR[1:0] != 2'b00)
      ar_resp = RESP_SLVERR;
  end

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      RVALID   <= 1'b0;
      RDATA    <= '0;
      RRESP    <= RESP_OKAY;
      mem_en   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_en <= 1'b0;
      if (ar_hs) begin
        addr_q <= ARADDR;
        if (ar_resp != RESP_OKAY) begin
          state  <= RESP;
          RVALID <= 1'b1;
          RDATA  <= '0;
          RRESP  <= ar_resp;
        end else begin
          RVALID <= 1'b0;
          if (LAT > 0) begin
            state <= WAIT;
            cnt   <= 4'(LAT - 1);
          end else begin
            state    <= ISSUE;
            mem_en   <= 1'b1;
            mem_addr <= word_idx(ARADDR);
          end
        end
      end else begin
        case (state)
          WAIT: begin
            if (cnt == 4'd0) begin
              state    <= ISSUE;
              mem_en   <= 1'b1;
              mem_addr <= word_idx(addr_q);
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ISSUE: state <= CAPT;
          CAPT: begin
            RDATA  <= mem_rdata;
            RRESP  <= RESP_OKAY;
            RVALID <= 1'b1;
            state  <= RESP;
          end
          RESP: begin
            if (RREADY) begin
              RVALID <= 1'b0;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_axil_slave.sv
// Directed bench for imem_axil_slave: one instance with LAT=0, one with LAT=3,
// each backed by a one-cycle-latency RAM model with known contents.
module tb_imem_axil_slave;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        arvalid  [2];
  logic [31:0] araddr   [2];
  logic        arready  [2];
  logic        rvalid   [2];
  logic [63:0] rdata    [2];
  logic [1:0]  rresp    [2];
  logic        rready   [2];
  logic        mem_en   [2];
  logic [15:0] mem_addr [2];

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] W0    = 64'h1111_2222_3333_4444;
  localparam logic [63:0] W1    = 64'hC0DE_0001_0000_FFFE;
  localparam logic [63:0] W2    = 64'hC0DE_0002_0000_FFFD;
  localparam logic [63:0] W3    = 64'hC0DE_0003_0000_FFFC;
  localparam logic [63:0] WLAST = 64'hC0DE_FFFF_0000_0000;

  function automatic logic [63:0] word_of(input logic [15:0] i);
    if (i == 16'd0) return 64'h1111_2222_3333_4444;
    return {16'hC0DE, i, 16'h0000, ~i};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [63:0] ram_q;
    imem_axil_slave #(.LAT(g == 0 ? 0 : 3)) dut (
      .clk       (clk),
      .rst       (rst),
      .ARVALID   (arvalid[g]),
      .ARADDR    (araddr[g]),
      .ARREADY   (arready[g]),
      .RVALID    (rvalid[g]),
      .RDATA     (rdata[g]),
      .RRESP     (rresp[g]),
      .RREADY    (rready[g]),
      .mem_en    (mem_en[g]),
      .mem_addr  (mem_addr[g]),
      .mem_rdata (ram_q)
    );
    // Data is only meaningful the cycle after a strobe; otherwise a poison value.
    always_ff @(posedge clk)
      ram_q <= mem_en[g] ? word_of(mem_addr[g]) : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Issue one read on instance d and check latency, response, data and RAM strobe.
  task automatic read_txn(input int d, input logic [31:0] addr, input logic [1:0] exp_resp,
                          input logic [63:0] exp_data, input int exp_lat, input logic [15:0] exp_idx);
    int          cyc     = 0;
    int          en_n    = 0;
    int          en_cyc  = -1;
    logic [15:0] en_addr = '0;
    arvalid[d] = 1'b1;
    araddr[d]  = addr;
    rready[d]  = 1'b1;
    #1;
    check($sformatf("arready %h", addr), 64'(arready[d]), 64'd1);
    do begin
      step();
      arvalid[d] = 1'b0;
      cyc++;
      #1;
      if (mem_en[d]) begin
        en_n++;
        en_cyc  = cyc;
        en_addr = mem_addr[d];
      end
    end while (!rvalid[d] && cyc < 40);
    check($sformatf("latency %h", addr), 64'(cyc), 64'(exp_lat));
    check($sformatf("rresp %h", addr), 64'(rresp[d]), 64'(exp_resp));
    check($sformatf("rdata %h", addr), rdata[d], exp_data);
    check($sformatf("mem_en count %h", addr), 64'(en_n), (exp_resp == 2'b00) ? 64'd1 : 64'd0);
    if (exp_resp == 2'b00) begin
      check($sformatf("mem_en cycle %h", addr), 64'(en_cyc), 64'(exp_lat - 2));
      check($sformatf("mem_addr %h", addr), 64'(en_addr), 64'(exp_idx));
    end
    step();
    #1;
    check($sformatf("rvalid drop %h", addr), 64'(rvalid[d]), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_w [3];
    logic [31:0] err_a [3];
    logic [1:0]  err_r [3];
    int          cyc;
    int          beats;
    int          issued;
    int          en_n;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      arvalid[i] = 1'b0;
      araddr[i]  = '0;
      rready[i]  = 1'b1;
    end
    repeat (2) step();
    #1;
    check("reset rvalid",   64'(rvalid[0]),   64'd0);
    check("reset rdata",    rdata[0],         64'd0);
    check("reset rresp",    64'(rresp[0]),    64'd0);
    check("reset mem_en",   64'(mem_en[0]),   64'd0);
    check("reset mem_addr", 64'(mem_addr[0]), 64'd0);
    check("reset arready0", 64'(arready[0]),  64'd0);
    check("reset arready1", 64'(arready[1]),  64'd0);
    step();
    rst = 1'b0;
    #1;
    check("post-reset arready", 64'(arready[0]), 64'd1);

    // Basic reads, both latencies, including the last word of the window.
    read_txn(0, 32'h8000_0000, 2'b00, W0, 3, 16'd0);
    read_txn(1, 32'h8000_0014, 2'b00, W2, 6, 16'd2);
    read_txn(0, 32'h8000_0004, 2'b00, W0, 3, 16'd0);
    read_txn(0, 32'h8007_FFF8, 2'b00, WLAST, 3, 16'hFFFF);

    // Error classification.
    read_txn(0, 32'h7FFF_FFFC, 2'b11, 64'd0, 1, 16'd0);
    read_txn(0, 32'h8000_0002, 2'b10, 64'd0, 1, 16'd0);
    read_txn(0, 32'h8008_0002, 2'b11, 64'd0, 1, 16'd0);
    read_txn(0, 32'h8008_0000, 2'b11, 64'd0, 1, 16'd0);

    // Back-pressure with a stray, out-of-range ARVALID while busy.
    arvalid[0] = 1'b1;
    araddr[0]  = 32'h8000_0008;
    rready[0]  = 1'b0;
    #1;
    check("bp arready idle", 64'(arready[0]), 64'd1);
    step();
    araddr[0] = 32'h7000_0000;
    cyc = 1;
    while (!rvalid[0] && cyc < 40) begin
      #1;
      check("bp arready busy", 64'(arready[0]), 64'd0);
      step();
      cyc++;
    end
    check("bp latency", 64'(cyc), 64'd3);
    for (int i = 0; i < 5; i++) begin
      araddr[0] = 32'h7000_0000 + 32'(i);
      #1;
      check("bp rvalid",  64'(rvalid[0]),  64'd1);
      check("bp rdata",   rdata[0],        W1);
      check("bp rresp",   64'(rresp[0]),   64'd0);
      check("bp arready", 64'(arready[0]), 64'd0);
      step();
    end
    rready[0]  = 1'b1;
    araddr[0]  = 32'h8000_0010;
    #1;
    check("bp release arready", 64'(arready[0]), 64'd1);
    cyc = 0;
    do begin
      step();
      arvalid[0] = 1'b0;
      cyc++;
    end while (!rvalid[0] && cyc < 40);
    check("bp next latency", 64'(cyc), 64'd3);
    check("bp next rdata",   rdata[0], W2);
    step();

    // Streaming OKAY reads: one beat every 3 cycles.
    exp_w[0] = W0;
    exp_w[1] = W0;
    exp_w[2] = W1;
    beats  = 0;
    issued = 0;
    for (int c = 0; c < 14; c++) begin
      if (rvalid[0]) begin
        if (beats < 3) begin
          check("stream rdata", rdata[0], exp_w[beats]);
          check("stream rresp", 64'(rresp[0]), 64'd0);
          check("stream cycle", 64'(c), 64'(3 * (beats + 1)));
        end
        beats++;
      end
      if (issued < 3) begin
        arvalid[0] = 1'b1;
        araddr[0]  = 32'h8000_0000 + 32'(4 * issued);
      end else begin
        arvalid[0] = 1'b0;
      end
      #1;
      if (arvalid[0] && arready[0]) issued++;
      step();
    end
    check("stream beats",  64'(beats),  64'd3);
    check("stream issued", 64'(issued), 64'd3);

    // Streaming errors: one response per cycle, no RAM strobes.
    err_a[0] = 32'h7000_0000; err_r[0] = 2'b11;
    err_a[1] = 32'h8000_0001; err_r[1] = 2'b10;
    err_a[2] = 32'h9000_0000; err_r[2] = 2'b11;
    beats  = 0;
    issued = 0;
    en_n   = 0;
    for (int c = 0; c < 8; c++) begin
      if (mem_en[0]) en_n++;
      if (rvalid[0]) begin
        if (beats < 3) begin
          check("err stream rresp", 64'(rresp[0]), 64'(err_r[beats]));
          check("err stream rdata", rdata[0], 64'd0);
          check("err stream cycle", 64'(c), 64'(beats + 1));
        end
        beats++;
      end
      if (issued < 3) begin
        arvalid[0] = 1'b1;
        araddr[0]  = err_a[issued];
      end else begin
        arvalid[0] = 1'b0;
      end
      #1;
      if (arvalid[0] && arready[0]) issued++;
      step();
    end
    check("err stream beats",  64'(beats), 64'd3);
    check("err stream mem_en", 64'(en_n),  64'd0);

    // Reset while in CAPT discards the access.
    arvalid[0] = 1'b1;
    araddr[0]  = 32'h8000_0018;
    step();
    arvalid[0] = 1'b0;
    #1;
    check("capt pre mem_en", 64'(mem_en[0]), 64'd1);
    step();
    rst = 1'b1;
    #1;
    check("capt rst rvalid",   64'(rvalid[0]),   64'd0);
    check("capt rst mem_en",   64'(mem_en[0]),   64'd0);
    check("capt rst mem_addr", 64'(mem_addr[0]), 64'd0);
    check("capt rst arready",  64'(arready[0]),  64'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("capt rst late rvalid", 64'(rvalid[0]), 64'd0);
    read_txn(0, 32'h8000_0018, 2'b00, W3, 3, 16'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_axil_slave.md
# imem_axil_slave

AXI-lite read-only responder for instruction memory: accepts read addresses on the AR channel, fetches one 64-bit word from a synchronous backing RAM after a programmable wait, and returns it on the R channel with a response code. It sits between the fetch unit's AXI-lite read master and the imem storage array. It supports one outstanding transaction, with back-to-back acceptance in the cycle the previous response is consumed.

## Interface
- ADDR_W, 32, AR address width (byte address)
- DATA_W, 64, R data width; fixed 64 (8-byte words)
- DEPTH, 65536, backing RAM depth in 64-bit words; power of two
- BASE, 32'h8000_0000, byte address of word 0; DEPTH*8-aligned
- LAT, 0, extra wait cycles before RAM access (0..15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ARVALID  in  1  read address valid
- ARADDR  in  ADDR_W  read byte address
- ARREADY  out  1  address accepted
- RVALID  out  1  read data valid
- RDATA  out  64  read word, 8-byte aligned, containing ARADDR
- RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR (misaligned), 2'b11 DECERR (out of range)
- RREADY  in  1  master accepts data
- mem_en  out  1  RAM read strobe, one cycle per access
- mem_addr  out  clog2(DEPTH)  RAM word index
- mem_rdata  in  64  RAM data, valid the cycle after mem_en

## Operation
- States: IDLE, WAIT, ISSUE, CAPT, RESP.
- AR handshake occurs when ARVALID && ARREADY. ARREADY = !rst && (state==IDLE || (state==RESP && RREADY)).
- On handshake the block registers addr_q = ARADDR and classifies it:
  - DECERR if ARADDR < BASE or ARADDR >= BASE+DEPTH*8.
  - Otherwise SLVERR if ARADDR[1:0] != 0.
  - Otherwise OKAY. DECERR takes priority over SLVERR.
- On OKAY: next state is WAIT with cnt=LAT-1 if LAT>0, else ISSUE.
- On error: next state is RESP, with RDATA=0 and the error code. mem_en is never asserted for an error.
- WAIT: decrements cnt; moves to ISSUE in the cycle cnt==0.
- ISSUE: mem_en=1, mem_addr=(addr_q-BASE)>>3; next state CAPT.
- CAPT: RDATA<=mem_rdata, RRESP<=2'b00; next state RESP.
- RESP: RVALID=1. RDATA and RRESP are held stable until RREADY.
  - RREADY && ARVALID: complete the current transaction and accept the new address in the same cycle; the next state is chosen as on an IDLE handshake.
  - RREADY && !ARVALID: go to IDLE.
- RDATA always carries the full aligned word; the master selects the 32-bit half using ARADDR[2].
- mem_addr holds its last value when mem_en=0.
- No write channels. AW/W/B are not implemented.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, cnt=0, addr_q=0.
  - RVALID=0, RDATA=0, RRESP=2'b00, mem_en=0, mem_addr=0.
  - ARREADY=0 while rst is high; ARREADY=1 in the first cycle after release.
- Reset mid-transaction discards the in-flight access. No RVALID is produced for it.
- OKAY latency: handshake in cycle N → mem_en in N+1+LAT → RVALID in N+3+LAT.
- Error latency: handshake in cycle N → RVALID in N+1.
- Throughput with RREADY held high and ARVALID held high:
  - one OKAY word every LAT+3 cycles;
  - one error response every cycle.
- ARVALID while busy (WAIT/ISSUE/CAPT, or RESP without RREADY): ARREADY=0. ARADDR changes during this time are ignored.
- RVALID never drops without RREADY.
- mem_en is high for exactly one cycle per OKAY transaction.

## Test plan
- Reset, LAT=0, RREADY=1: ARVALID=1, ARADDR=0x8000_0000 at cycle 0, RAM word 0 = 0x1111_2222_3333_4444 → mem_en at cycle 1 with mem_addr=0; RVALID=1 at cycle 3 with RDATA=0x1111_2222_3333_4444 and RRESP=00.
- LAT=3, ARADDR=0x8000_0014 → mem_en at cycle 4 with mem_addr=2; RVALID at cycle 6 with RRESP=00.
- Back-pressure: RREADY=0 for 5 cycles after RVALID → RDATA/RRESP stable and ARREADY=0 throughout. RREADY=1 with a new ARVALID → handshake in that cycle; next RVALID 3 cycles later.
- ARADDR=0x7FFF_FFFC → RVALID next cycle, RRESP=11, RDATA=0, no mem_en. ARADDR=0x8000_0002 → RRESP=10. ARADDR=BASE+DEPTH*8+2 → RRESP=11 (DECERR has priority).
- Streaming: ARVALID/RREADY held high with sequential addresses 0x8000_0000, +4, +8, LAT=0 → a new RVALID every 3 cycles with words 0, 0, 1, and no dropped or duplicated beats.
- Assert rst in the CAPT state → RVALID=0 and mem_en=0 immediately; after release, the first AR is accepted and returns correct data.
